// File: rtl/video_rot_ram_port.sv
// video_rot_ram_port
// Burst adapter between the rotation stage of the video pipeline and a
// single-word SDRAM client port. Write bursts (vidin_*) and read bursts
// (vidout_*) are split into individual RAM word transactions. A per-word
// ack strobe paces the pipeline. Reads win arbitration at burst boundaries.
// Bursts are never interleaved.
//
// Ports
//   clk_sys, reset_n        : system clock, asynchronous active-low reset
//   vidin_req/frame/row/col : write burst request and its position
//   vidin_d, vidin_ack      : current write word / word-consumed strobe
//   vidout_req/frame/row/col: read burst request and its position
//   vidout_d, vidout_ack    : read word / word-valid strobe
//   ram_req/we/addr/d       : word transaction towards the RAM client port
//   ram_q, ram_ack          : read data and completion of the current word
module video_rot_ram_port #(
  parameter int ADDR_WIDTH = 22,
  parameter int BASE_ADDR  = 0,
  parameter int IN_BURST   = 16,
  parameter int OUT_BURST  = 8
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  vidin_req,
  input  logic                  vidin_frame,
  input  logic [9:0]            vidin_row,
  input  logic [9:0]            vidin_col,
  input  logic [15:0]           vidin_d,
  output logic                  vidin_ack,
  input  logic                  vidout_req,
  input  logic                  vidout_frame,
  input  logic [9:0]            vidout_row,
  input  logic [9:0]            vidout_col,
  output logic [15:0]           vidout_d,
  output logic                  vidout_ack,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [15:0]           ram_d,
  input  logic [15:0]           ram_q,
  input  logic                  ram_ack
);

  typedef enum logic [2:0] {
    IDLE, WR_ISSUE, WR_DONE, WR_GAP, RD_ISSUE, RD_DONE, RD_GAP
  } state_t;

  // {frame,row,col} is 21 bits; the sum is formed at least that wide and
  // then truncated to the RAM address width.
  localparam int         SUM_W    = (ADDR_WIDTH > 21) ? ADDR_WIDTH : 21;
  localparam logic [9:0] IN_LAST  = 10'(IN_BURST - 1);
  localparam logic [9:0] OUT_LAST = 10'(OUT_BURST - 1);

  state_t           state_reg;
  logic [9:0]       wcnt_reg;
  logic             frame_reg;
  logic [9:0]       row_reg;
  logic [9:0]       col_reg;
  logic             in_armed_reg;
  logic             out_armed_reg;

  logic [9:0]       col_next;
  logic [SUM_W-1:0] addr_next;

  // Column wraps inside the row: the 10-bit add drops the carry on purpose.
  assign col_next  = col_reg + wcnt_reg;
  assign addr_next = SUM_W'(BASE_ADDR) + SUM_W'({frame_reg, row_reg, col_next});

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      wcnt_reg      <= '0;
      frame_reg     <= 1'b0;
      row_reg       <= '0;
      col_reg       <= '0;
      in_armed_reg  <= 1'b1;
      out_armed_reg <= 1'b1;
      ram_req       <= 1'b0;
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_d         <= '0;
      vidin_ack     <= 1'b0;
      vidout_ack    <= 1'b0;
      vidout_d      <= '0;
    end else begin
      // Strobes last exactly one cycle (the DONE state).
      vidin_ack  <= 1'b0;
      vidout_ack <= 1'b0;

      // A channel may start a new burst only after its req was seen low.
      if (!vidin_req)  in_armed_reg  <= 1'b1;
      if (!vidout_req) out_armed_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (vidout_req && out_armed_reg) begin
            state_reg <= RD_ISSUE;
            wcnt_reg  <= '0;
            frame_reg <= vidout_frame;
            row_reg   <= vidout_row;
            col_reg   <= vidout_col;
          end else if (vidin_req && in_armed_reg) begin
            state_reg <= WR_ISSUE;
            wcnt_reg  <= '0;
            frame_reg <= vidin_frame;
            row_reg   <= vidin_row;
            col_reg   <= vidin_col;
          end
        end

        // First ISSUE cycle launches the request; it then holds
        // address/data/we stable until the RAM acknowledges.
        WR_ISSUE: begin
          if (!ram_req) begin
            ram_req  <= 1'b1;
            ram_we   <= 1'b1;
            ram_d    <= vidin_d;
            ram_addr <= addr_next[ADDR_WIDTH-1:0];
          end else if (ram_ack) begin
            ram_req   <= 1'b0;
            vidin_ack <= 1'b1;
            state_reg <= WR_DONE;
          end
        end

        WR_DONE: begin
          wcnt_reg <= wcnt_reg + 10'd1;
          if (!vidin_req) begin
            state_reg <= IDLE;              // abandoned, stays armed
          end else if (wcnt_reg == IN_LAST) begin
            in_armed_reg <= 1'b0;
            state_reg    <= IDLE;
          end else begin
            state_reg <= WR_GAP;
          end
        end

        // Gives the source a cycle to present the next vidin_d.
        WR_GAP: state_reg <= WR_ISSUE;

        RD_ISSUE: begin
          if (!ram_req) begin
            ram_req  <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= addr_next[ADDR_WIDTH-1:0];
          end else if (ram_ack) begin
            ram_req    <= 1'b0;
            vidout_d   <= ram_q;
            vidout_ack <= 1'b1;
            state_reg  <= RD_DONE;
          end
        end

        RD_DONE: begin
          wcnt_reg <= wcnt_reg + 10'd1;
          if (!vidout_req) begin
            state_reg <= IDLE;
          end else if (wcnt_reg == OUT_LAST) begin
            out_armed_reg <= 1'b0;
            state_reg     <= IDLE;
          end else begin
            state_reg <= RD_GAP;
          end
        end

        RD_GAP: state_reg <= RD_ISSUE;

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/video_rot_ram_port.md
# video_rot_ram_port

Burst adapter between the video pipeline's rotation memory interface (`vidin_*` write bursts, `vidout_*` read bursts) and a single-word SDRAM client port. It sits directly downstream of the video pipeline's scandoubler/rotation stage. It serialises 16-word write bursts and 8-word read bursts into individual RAM word transactions and generates the per-word `vidin_ack`/`vidout_ack` strobes that pace the pipeline. Read bursts have priority over write bursts at burst boundaries. A burst is never interleaved with another burst.

## Interface
Parameters:
- `ADDR_WIDTH`, 22: RAM word address width.
- `BASE_ADDR`, 0: word offset of the framebuffer region in RAM.
- `IN_BURST`, 16: words per `vidin` burst.
- `OUT_BURST`, 8: words per `vidout` burst.

Ports:
- `clk_sys` in 1: system clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `vidin_req` in 1: write burst pending; held until the burst is delivered.
- `vidin_frame` in 1: buffer select for the write.
- `vidin_row` in 10: row of the write burst.
- `vidin_col` in 10: start column of the write burst.
- `vidin_d` in 16: current write word.
- `vidin_ack` out 1: one-cycle strobe; the current word is consumed.
- `vidout_req` in 1: read burst pending.
- `vidout_frame` in 1: buffer select for the read.
- `vidout_row` in 10: row of the read burst.
- `vidout_col` in 10: start column of the read burst.
- `vidout_d` out 16: read word.
- `vidout_ack` out 1: one-cycle strobe; `vidout_d` is valid.
- `ram_req` out 1: word transaction request.
- `ram_we` out 1: 1 = write, 0 = read.
- `ram_addr` out ADDR_WIDTH: word address.
- `ram_d` out 16: write data.
- `ram_q` in 16: read data; valid in the `ram_ack` cycle.
- `ram_ack` in 1: one-cycle completion of the current word.

## Operation
- **Address:** `ram_addr = BASE_ADDR + {frame, row, (col + wcnt) mod 1024}`, truncated to ADDR_WIDTH.
  - Column wraps within the row; it never carries into the row field.
  - frame/row/col are latched at burst start and ignored during the burst.
- **State machine:** IDLE, WR_ISSUE, WR_DONE, WR_GAP, RD_ISSUE, RD_DONE, RD_GAP.
- **Arming:** each channel has an `armed` flag, set at reset.
  - Cleared when that channel's burst completes.
  - Re-set when its req is sampled low.
  - A req that stays high after its burst completes starts no new burst until it drops at least one cycle.
- **IDLE transitions:**
  - `vidout_req & out_armed` → RD_ISSUE. This takes priority.
  - Otherwise `vidin_req & in_armed` → WR_ISSUE.
  - Entering a burst: `wcnt` = 0 and latch frame/row/col.
- **WR_ISSUE:**
  - On entry: `ram_d` ← `vidin_d`, `ram_we` = 1, `ram_req` = 1.
  - Address and data stay stable until `ram_ack`; then go to WR_DONE.
- **WR_DONE:** `ram_req` = 0, `vidin_ack` = 1 for this cycle, `wcnt`++.
  - If `wcnt` was IN_BURST-1: clear `in_armed`, go to IDLE.
  - Otherwise go to WR_GAP.
- **WR_GAP:** one idle cycle so the source can update `vidin_d`; then go to WR_ISSUE.
- **RD_ISSUE:** `ram_we` = 0, `ram_req` = 1 until `ram_ack`.
  - In the `ram_ack` cycle, capture `ram_q` into `vidout_d`, then go to RD_DONE.
- **RD_DONE:** `vidout_ack` = 1 for this cycle, `wcnt`++.
  - Completion at OUT_BURST-1 is handled the same way as writes (clear `out_armed`, go to IDLE).
  - Otherwise go to RD_GAP, then RD_ISSUE.
- **Req drop mid-burst:** the burst is abandoned at the next word boundary, i.e. in WR_DONE/RD_DONE when the corresponding req is low. Go to IDLE; `armed` stays set.
- **`ram_ack` outside an ISSUE state:** ignored.
- `vidout_d` holds its last value between strobes.

## Timing
- **Reset values:** `ram_req`=0, `ram_we`=0, `ram_addr`=0, `ram_d`=0, `vidin_ack`=0, `vidout_ack`=0, `vidout_d`=0, state=IDLE, `wcnt`=0, both `armed`=1.
- **Mid-transaction reset:** reset is applied asynchronously, including during a transaction. `ram_req` falls immediately and the burst is discarded.
- **Request latency:** req sampled high in IDLE at edge N → `ram_req` high after edge N+1.
- **Per-word latency:** `ram_ack` at edge M → ack strobe high during M..M+1.
- **Word spacing:** next `ram_req` after M+2 (after the gap cycle).
- **Minimum per word:** 4 cycles with a zero-wait RAM (ack in the first request cycle).
- **Arbitration:** both reqs rising in the same cycle → the read burst is fully served first, then the write burst.
- **Strobes:** `vidin_ack` and `vidout_ack` are never high in the same cycle and never high for 2 consecutive cycles.

## Test plan
- **Single write burst:** BASE=0, frame=1, row=5, col=32, RAM acks 1 cycle after req.
  - Exactly 16 writes at addresses 0x101420..0x10142F.
  - 16 `vidin_ack` pulses; data matches `vidin_d` in order.
- **Single read burst:** row=2, col=1020.
  - 8 reads; column wraps 1020..1023 then 0..3 within row 2.
  - `vidout_d` equals the `ram_q` model at each `vidout_ack`.
- **Priority:** `vidin_req` and `vidout_req` rise in the same cycle.
  - All 8 reads complete before the first write `ram_req`.
  - No interleaving.
- **Held req:** `vidin_req` kept high for 40 cycles after the 16th ack.
  - No further writes.
  - Drop req one cycle, then raise it again → a new 16-word burst starts.
- **Variable RAM latency:** `ram_ack` delayed 0–7 random cycles.
  - `ram_addr`/`ram_d`/`ram_we` stay stable while `ram_req` is high.
  - Strobe count is exact.
- **Reset mid-burst:** `reset_n` low after word 5.
  - All outputs go to reset values immediately.
  - After release with req high → a full burst restarts from `wcnt`=0.
